// File: rtl/wave_dispatcher.sv
// Splits one thread block at a time into WAVE_SIZE-thread waves and issues them to free SIMDs
// over the simd_start/simd_ready/simd_done handshake, pulsing block_done once every wave has returned.
module wave_dispatcher #(
    parameter int NUM_SIMDS = 4,
    parameter int WAVE_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  block_valid,
    output logic                  block_ready,
    input  logic signed [31:0]    block_id,
    input  logic [31:0]           block_dim,
    output logic                  block_done,
    input  logic [NUM_SIMDS-1:0]  simd_ready,
    input  logic [NUM_SIMDS-1:0]  simd_done,
    output logic [NUM_SIMDS-1:0]  simd_start,
    output logic signed [31:0]    dispatch_block_id,
    output logic [31:0]           dispatch_wave_id,
    output logic [31:0]           num_waves_in_block
);

    localparam int         WAVE_SHIFT = $clog2(WAVE_SIZE);
    localparam logic [32:0] WAVE_ROUND = 33'(WAVE_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        DONE
    } state_e;

    state_e                state_q;
    logic [NUM_SIMDS-1:0]  busy_q;
    logic [31:0]           next_wave_q;
    logic [31:0]           completed_q;
    logic signed [31:0]    blk_id_q;
    logic [31:0]           num_waves_q;
    logic [NUM_SIMDS-1:0]  simd_start_q;
    logic                  block_done_q;
    logic signed [31:0]    disp_block_id_q;
    logic [31:0]           disp_wave_id_q;

    logic [NUM_SIMDS-1:0]  eligible;
    logic [NUM_SIMDS-1:0]  pick_oh;
    logic                  have_pick;
    logic [NUM_SIMDS-1:0]  done_hit;
    logic [31:0]           done_cnt;
    logic [31:0]           completed_d;
    logic [32:0]           dim_sum;
    logic [32:0]           dim_shifted;
    logic [31:0]           num_waves_new;
    logic                  last_wave;

    // NOTE: every signal written here gets a value before any conditional update, so no latch is inferred.
    always_comb begin
        eligible  = simd_ready & ~busy_q;
        // Two's-complement trick isolates the lowest set bit: lowest-index eligible SIMD wins.
        pick_oh   = eligible & (~eligible + NUM_SIMDS'(1));
        have_pick = |eligible;

        done_hit = (state_q != IDLE) ? (simd_done & busy_q) : '0;
        done_cnt = '0;
        for (int i = 0; i < NUM_SIMDS; i++) begin
            done_cnt = done_cnt + {31'b0, done_hit[i]};
        end
        completed_d = completed_q + done_cnt;

        // 33-bit sum keeps the ceiling divide exact at block_dim = 0xFFFFFFFF.
        dim_sum       = {1'b0, block_dim} + WAVE_ROUND;
        dim_shifted   = dim_sum >> WAVE_SHIFT;
        num_waves_new = dim_shifted[31:0];

        last_wave = (next_wave_q == num_waves_q - 32'd1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            busy_q          <= '0;
            next_wave_q     <= '0;
            completed_q     <= '0;
            blk_id_q        <= '0;
            num_waves_q     <= '0;
            simd_start_q    <= '0;
            block_done_q    <= 1'b0;
            disp_block_id_q <= '0;
            disp_wave_id_q  <= '0;
        end else begin
            simd_start_q <= '0;
            block_done_q <= 1'b0;
            busy_q       <= busy_q & ~done_hit;
            completed_q  <= completed_d;

            case (state_q)
                IDLE: begin
                    if (block_valid) begin
                        blk_id_q    <= block_id;
                        num_waves_q <= num_waves_new;
                        completed_q <= '0;
                        next_wave_q <= '0;
                        if (num_waves_new == '0) begin
                            state_q      <= DONE;
                            block_done_q <= 1'b1;
                        end else if (have_pick) begin
                            // Wave 0 issues on the acceptance edge so it is visible the next cycle.
                            simd_start_q    <= pick_oh;
                            busy_q          <= busy_q | pick_oh;
                            disp_block_id_q <= block_id;
                            disp_wave_id_q  <= '0;
                            next_wave_q     <= 32'd1;
                            state_q         <= (num_waves_new == 32'd1) ? DRAIN : DISPATCH;
                        end else begin
                            state_q <= DISPATCH;
                        end
                    end
                end

                DISPATCH: begin
                    if (have_pick) begin
                        simd_start_q    <= pick_oh;
                        busy_q          <= (busy_q & ~done_hit) | pick_oh;
                        disp_block_id_q <= blk_id_q;
                        disp_wave_id_q  <= next_wave_q;
                        next_wave_q     <= next_wave_q + 32'd1;
                        if (last_wave) begin
                            state_q <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (completed_d == num_waves_q) begin
                        state_q      <= DONE;
                        block_done_q <= 1'b1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign block_ready        = (state_q == IDLE);
    assign block_done         = block_done_q;
    assign simd_start         = simd_start_q;
    assign dispatch_block_id  = disp_block_id_q;
    assign dispatch_wave_id   = disp_wave_id_q;
    assign num_waves_in_block = num_waves_q;

endmodule

// File: tb/tb_wave_dispatcher.sv
// Directed bench for wave_dispatcher: each step drives inputs just after a rising edge and
// checks the registered outputs against hand-computed values one time unit after that edge.
module tb_wave_dispatcher;

    localparam int NUM_SIMDS = 4;
    localparam int WAVE_SIZE = 32;

    logic                  clk;
    logic                  rst;
    logic                  block_valid;
    logic                  block_ready;
    logic signed [31:0]    block_id;
    logic [31:0]           block_dim;
    logic                  block_done;
    logic [NUM_SIMDS-1:0]  simd_ready;
    logic [NUM_SIMDS-1:0]  simd_done;
    logic [NUM_SIMDS-1:0]  simd_start;
    logic signed [31:0]    dispatch_block_id;
    logic [31:0]           dispatch_wave_id;
    logic [31:0]           num_waves_in_block;

    int n_checks = 0;
    int n_pass   = 0;

    wave_dispatcher #(
        .NUM_SIMDS (NUM_SIMDS),
        .WAVE_SIZE (WAVE_SIZE)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .block_valid        (block_valid),
        .block_ready        (block_ready),
        .block_id           (block_id),
        .block_dim          (block_dim),
        .block_done         (block_done),
        .simd_ready         (simd_ready),
        .simd_done          (simd_done),
        .simd_start         (simd_start),
        .dispatch_block_id  (dispatch_block_id),
        .dispatch_wave_id   (dispatch_wave_id),
        .num_waves_in_block (num_waves_in_block)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic signed [31:0] id, input logic [31:0] dim);
        block_id    = id;
        block_dim   = dim;
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        block_valid = 1'b0;
        block_id    = '0;
        block_dim   = '0;
        simd_ready  = 4'b1111;
        simd_done   = 4'b0000;

        #3;
        check("rst_ready", 32'(block_ready), 32'd1);
        check("rst_start", 32'(simd_start), 32'd0);
        check("rst_done", 32'(block_done), 32'd0);
        check("rst_bid", dispatch_block_id, 32'd0);
        check("rst_wid", dispatch_wave_id, 32'd0);
        check("rst_nw", num_waves_in_block, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Single wave: 20 threads -> 1 wave on SIMD 0.
        accept(32'sd7, 32'd20);
        check("sw_start", 32'(simd_start), 32'h1);
        check("sw_wid", dispatch_wave_id, 32'd0);
        check("sw_bid", dispatch_block_id, 32'd7);
        check("sw_nw", num_waves_in_block, 32'd1);
        check("sw_ready", 32'(block_ready), 32'd0);
        simd_done = 4'b0001;
        tick();
        simd_done = 4'b0000;
        check("sw_done", 32'(block_done), 32'd1);
        check("sw_start_off", 32'(simd_start), 32'd0);
        tick();
        check("sw_done_off", 32'(block_done), 32'd0);
        check("sw_ready_again", 32'(block_ready), 32'd1);

        // Fill and stall: 160 threads -> 5 waves; a competing block_valid must be ignored.
        accept(-32'sd3, 32'd160);
        block_valid = 1'b1;
        block_id    = 32'sd99;
        block_dim   = 32'd33;
        check("fs_start0", 32'(simd_start), 32'h1);
        check("fs_nw", num_waves_in_block, 32'd5);
        tick();
        check("fs_start1", 32'(simd_start), 32'h2);
        check("fs_wid1", dispatch_wave_id, 32'd1);
        check("fs_ignore_ready", 32'(block_ready), 32'd0);
        tick();
        check("fs_start2", 32'(simd_start), 32'h4);
        tick();
        check("fs_start3", 32'(simd_start), 32'h8);
        check("fs_wid3", dispatch_wave_id, 32'd3);
        tick();
        block_valid = 1'b0;
        check("fs_stall", 32'(simd_start), 32'h0);
        check("fs_hold_wid", dispatch_wave_id, 32'd3);
        check("fs_ignore_nw", num_waves_in_block, 32'd5);
        simd_done = 4'b0100;
        tick();
        simd_done = 4'b0000;
        check("fs_no_same_edge", 32'(simd_start), 32'h0);
        tick();
        check("fs_start4", 32'(simd_start), 32'h4);
        check("fs_wid4", dispatch_wave_id, 32'd4);
        check("fs_bid4", dispatch_block_id, 32'hFFFF_FFFD);
        simd_done = 4'b0001;
        tick();
        check("fs_done_early1", 32'(block_done), 32'd0);
        simd_done = 4'b0001;
        tick();
        check("fs_spurious", 32'(block_done), 32'd0);
        simd_done = 4'b1010;
        tick();
        check("fs_done_early2", 32'(block_done), 32'd0);
        simd_done = 4'b0100;
        tick();
        simd_done = 4'b0000;
        check("fs_done", 32'(block_done), 32'd1);
        tick();
        check("fs_done_off", 32'(block_done), 32'd0);
        check("fs_ready_again", 32'(block_ready), 32'd1);

        // Empty block: no waves, done right after acceptance, previous dispatch values held.
        accept(32'sd5, 32'd0);
        check("em_done", 32'(block_done), 32'd1);
        check("em_start", 32'(simd_start), 32'd0);
        check("em_nw", num_waves_in_block, 32'd0);
        check("em_hold_bid", dispatch_block_id, 32'hFFFF_FFFD);
        tick();
        check("em_done_off", 32'(block_done), 32'd0);
        check("em_ready", 32'(block_ready), 32'd1);

        // Four waves then all four dones in one cycle.
        accept(32'sd11, 32'd128);
        check("sim_start0", 32'(simd_start), 32'h1);
        tick();
        tick();
        tick();
        check("sim_start3", 32'(simd_start), 32'h8);
        check("sim_wid3", dispatch_wave_id, 32'd3);
        tick();
        check("sim_idle", 32'(simd_start), 32'h0);
        simd_done = 4'b1111;
        tick();
        simd_done = 4'b0000;
        check("sim_done", 32'(block_done), 32'd1);
        tick();
        check("sim_ready", 32'(block_ready), 32'd1);

        // 33 threads -> 2 waves, accepted while no SIMD is ready, then lowest ready index wins.
        simd_ready = 4'b0000;
        accept(32'sd42, 32'd33);
        check("b33_nw", num_waves_in_block, 32'd2);
        check("b33_stall", 32'(simd_start), 32'h0);
        simd_ready = 4'b0110;
        tick();
        check("b33_start0", 32'(simd_start), 32'h2);
        check("b33_wid0", dispatch_wave_id, 32'd0);
        check("b33_bid0", dispatch_block_id, 32'd42);
        tick();
        check("b33_start1", 32'(simd_start), 32'h4);
        check("b33_wid1", dispatch_wave_id, 32'd1);
        tick();
        check("b33_drain", 32'(simd_start), 32'h0);
        simd_done = 4'b0110;
        tick();
        simd_done  = 4'b0000;
        simd_ready = 4'b1111;
        check("b33_done", 32'(block_done), 32'd1);
        tick();
        check("b33_ready", 32'(block_ready), 32'd1);

        // Maximum block_dim, then reset in the middle of dispatch with two waves outstanding.
        accept(32'sd1, 32'hFFFF_FFFF);
        check("max_nw", num_waves_in_block, 32'h0800_0000);
        check("max_start0", 32'(simd_start), 32'h1);
        tick();
        check("max_start1", 32'(simd_start), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        check("mr_start", 32'(simd_start), 32'h0);
        check("mr_ready", 32'(block_ready), 32'd1);
        check("mr_nw", num_waves_in_block, 32'd0);
        #1;
        rst = 1'b1;
        tick();
        simd_done = 4'b0011;
        tick();
        simd_done = 4'b0000;
        check("mr_no_done1", 32'(block_done), 32'd0);
        check("mr_ready1", 32'(block_ready), 32'd1);
        tick();
        check("mr_no_done2", 32'(block_done), 32'd0);
        check("mr_no_start", 32'(simd_start), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
